// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO slice.
package sync_fifo_pkg;

    // One extra pointer bit acts as the wrap flag that separates full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for sync_fifo: synchronous write, asynchronous read.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with valid/grant handshakes and sticky error flags.
module sync_fifo #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH           = 4,
    parameter int ALMOST_FULL_THR = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid_i,
    input  logic [DATA_WIDTH-1:0]      push_data_i,
    output logic                       push_grant_o,
    output logic                       pop_valid_o,
    output logic [DATA_WIDTH-1:0]      pop_data_o,
    input  logic                       pop_grant_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       almost_full_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);
    import sync_fifo_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] AF_THR  = CW'(ALMOST_FULL_THR);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  empty;
    logic                  full;
    logic                  push_fire;
    logic                  pop_fire;
    logic [DATA_WIDTH-1:0] head_data;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign push_grant_o = !full && !rst;
    assign pop_valid_o  = !empty;
    assign push_fire    = push_valid_i && push_grant_o;
    assign pop_fire     = pop_valid_o && pop_grant_i;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_fire),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (push_data_i),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head_data)
    );

    assign pop_data_o    = empty ? '0 : head_data;
    assign count_o       = count_q;
    assign almost_full_o = (count_q >= AF_THR);
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_fire, pop_fire})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (push_valid_i && full) begin
                overflow_q <= 1'b1;
            end
            if (pop_grant_i && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DATA_WIDTH=8, DEPTH=4) with hand-computed expectations.
module tb_sync_fifo;

    logic       clk;
    logic       rst;
    logic       push_valid_i;
    logic [7:0] push_data_i;
    logic       push_grant_o;
    logic       pop_valid_o;
    logic [7:0] pop_data_o;
    logic       pop_grant_i;
    logic [2:0] count_o;
    logic       almost_full_o;
    logic       overflow_o;
    logic       underflow_o;

    int total = 0;
    int bad   = 0;

    sync_fifo #(
        .DATA_WIDTH      (8),
        .DEPTH           (4),
        .ALMOST_FULL_THR (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push_valid_i  (push_valid_i),
        .push_data_i   (push_data_i),
        .push_grant_o  (push_grant_o),
        .pop_valid_o   (pop_valid_o),
        .pop_data_o    (pop_data_o),
        .pop_grant_i   (pop_grant_i),
        .count_o       (count_o),
        .almost_full_o (almost_full_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic pv, input logic [7:0] pd, input logic pg);
        push_valid_i = pv;
        push_data_i  = pd;
        pop_grant_i  = pg;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst          = 1'b1;
        push_valid_i = 1'b1;
        push_data_i  = 8'hAA;
        pop_grant_i  = 1'b0;

        // Reset held for two edges with a push pending.
        @(posedge clk);
        #1;
        checkOutput("rst1_grant", push_grant_o, 0);
        checkOutput("rst1_count", count_o, 0);
        @(posedge clk);
        #1;
        checkOutput("rst2_grant", push_grant_o, 0);
        checkOutput("rst2_count", count_o, 0);
        push_valid_i = 1'b0;
        rst          = 1'b0;
        #1;
        checkOutput("rel_grant", push_grant_o, 1);
        checkOutput("rel_valid", pop_valid_o, 0);
        checkOutput("rel_data", pop_data_o, 0);
        checkOutput("rel_af", almost_full_o, 0);
        checkOutput("rel_ovf", overflow_o, 0);
        checkOutput("rel_unf", underflow_o, 0);

        // Fill to full, then try an extra word.
        applyStimulus(1, 8'h01, 0);
        checkOutput("fill1_count", count_o, 1);
        checkOutput("fill1_valid", pop_valid_o, 1);
        checkOutput("fill1_head", pop_data_o, 8'h01);
        checkOutput("fill1_af", almost_full_o, 0);
        applyStimulus(1, 8'h03, 0);
        checkOutput("fill2_count", count_o, 2);
        checkOutput("fill2_af", almost_full_o, 0);
        applyStimulus(1, 8'h07, 0);
        checkOutput("fill3_count", count_o, 3);
        checkOutput("fill3_af", almost_full_o, 1);
        checkOutput("fill3_grant", push_grant_o, 1);
        applyStimulus(1, 8'h0F, 0);
        checkOutput("fill4_count", count_o, 4);
        checkOutput("fill4_grant", push_grant_o, 0);
        checkOutput("fill4_ovf", overflow_o, 0);
        applyStimulus(1, 8'hFF, 0);
        checkOutput("ovf_flag", overflow_o, 1);
        checkOutput("ovf_count", count_o, 4);
        checkOutput("ovf_head", pop_data_o, 8'h01);

        // Drain in order.
        applyStimulus(0, 8'h00, 1);
        checkOutput("drain1_head", pop_data_o, 8'h03);
        checkOutput("drain1_count", count_o, 3);
        applyStimulus(0, 8'h00, 1);
        checkOutput("drain2_head", pop_data_o, 8'h07);
        applyStimulus(0, 8'h00, 1);
        checkOutput("drain3_head", pop_data_o, 8'h0F);
        checkOutput("drain3_count", count_o, 1);
        applyStimulus(0, 8'h00, 0);
        checkOutput("drain3_hold", pop_data_o, 8'h0F);
        applyStimulus(0, 8'h00, 1);
        checkOutput("drain4_valid", pop_valid_o, 0);
        checkOutput("drain4_data", pop_data_o, 0);
        checkOutput("drain4_count", count_o, 0);
        checkOutput("drain4_unf", underflow_o, 0);

        // Wrap-around at steady occupancy of two.
        applyStimulus(1, 8'h10, 0);
        applyStimulus(1, 8'h11, 0);
        checkOutput("wrap_pre_count", count_o, 2);
        checkOutput("wrap_pre_head", pop_data_o, 8'h10);
        for (int i = 2; i < 10; i++) begin
            applyStimulus(1, 8'(8'h10 + i), 1);
            checkOutput($sformatf("wrap%0d_head", i), pop_data_o, 32'(8'h10 + i - 1));
            checkOutput($sformatf("wrap%0d_count", i), count_o, 2);
        end
        applyStimulus(0, 8'h00, 1);
        checkOutput("wrap_tail_head", pop_data_o, 8'h19);
        checkOutput("wrap_tail_count", count_o, 1);
        applyStimulus(0, 8'h00, 1);
        checkOutput("wrap_empty", pop_valid_o, 0);

        // Full with push and pop together: pop only.
        applyStimulus(1, 8'hA0, 0);
        applyStimulus(1, 8'hA1, 0);
        applyStimulus(1, 8'hA2, 0);
        applyStimulus(1, 8'hA3, 0);
        checkOutput("bfull_count", count_o, 4);
        applyStimulus(1, 8'hA4, 1);
        checkOutput("bfull_pp_count", count_o, 3);
        checkOutput("bfull_pp_head", pop_data_o, 8'hA1);
        applyStimulus(0, 8'h00, 1);
        checkOutput("bfull_d1", pop_data_o, 8'hA2);
        applyStimulus(0, 8'h00, 1);
        checkOutput("bfull_d2", pop_data_o, 8'hA3);
        applyStimulus(0, 8'h00, 1);
        checkOutput("bfull_d3_valid", pop_valid_o, 0);
        checkOutput("bfull_d3_count", count_o, 0);

        // Empty with push and grant together: push only, underflow recorded.
        applyStimulus(1, 8'hB0, 1);
        checkOutput("bempty_count", count_o, 1);
        checkOutput("bempty_unf", underflow_o, 1);
        checkOutput("bempty_head", pop_data_o, 8'hB0);
        applyStimulus(0, 8'h00, 1);
        checkOutput("bempty_drain", count_o, 0);

        // Consumer holding grant: each word shown one cycle after push, removed on grant.
        applyStimulus(1, 8'h01, 1);
        checkOutput("pc1_valid", pop_valid_o, 1);
        checkOutput("pc1_head", pop_data_o, 8'h01);
        applyStimulus(1, 8'h81, 1);
        checkOutput("pc2_head", pop_data_o, 8'h81);
        checkOutput("pc2_count", count_o, 1);
        applyStimulus(0, 8'h00, 1);
        checkOutput("pc3_valid", pop_valid_o, 0);
        checkOutput("pc3_count", count_o, 0);

        // Reset mid-stream with three entries held and a concurrent push.
        applyStimulus(1, 8'hC0, 0);
        applyStimulus(1, 8'hC1, 0);
        applyStimulus(1, 8'hC2, 0);
        checkOutput("mid_pre_count", count_o, 3);
        checkOutput("mid_pre_ovf", overflow_o, 1);
        rst = 1'b1;
        applyStimulus(1, 8'hC3, 1);
        checkOutput("mid_count", count_o, 0);
        checkOutput("mid_valid", pop_valid_o, 0);
        checkOutput("mid_data", pop_data_o, 0);
        checkOutput("mid_ovf", overflow_o, 0);
        checkOutput("mid_unf", underflow_o, 0);
        checkOutput("mid_grant", push_grant_o, 0);
        rst = 1'b0;
        applyStimulus(0, 8'h00, 0);
        checkOutput("post_count", count_o, 0);
        checkOutput("post_valid", pop_valid_o, 0);
        checkOutput("post_grant", push_grant_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
